// File: rtl/soundgen_tone_player_if.sv
// soundgen_tone_player_if
// Note-command channel between a note sequencer (master) and the tone
// player (slave).
//   note_valid_i   master -> slave  command valid
//   note_ready_o   slave  -> master player can take a command
//   note_period_i  master -> slave  half-period in clock cycles, 0 = rest
//   note_dur_i     master -> slave  note length in duration ticks
interface soundgen_tone_player_if #(
  parameter int PERIOD_BW = 12,
  parameter int DUR_BW    = 8
);
  logic                 note_valid_i;
  logic                 note_ready_o;
  logic [PERIOD_BW-1:0] note_period_i;
  logic [DUR_BW-1:0]    note_dur_i;

  modport master (
    output note_valid_i,
    output note_period_i,
    output note_dur_i,
    input  note_ready_o
  );

  modport slave (
    input  note_valid_i,
    input  note_period_i,
    input  note_dur_i,
    output note_ready_o
  );
endinterface

// File: rtl/soundgen_tone_player.sv
// soundgen_tone_player
// Plays one (period, duration) note at a time as a 1-bit square wave,
// follows it with a fixed silent gap, then pulses note_done_o.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   note         note-command channel (slave side)
//   audio_o      registered square-wave output
//   busy_o       high while a note or its gap is in progress
//   note_done_o  registered one-cycle completion pulse
module soundgen_tone_player #(
  parameter int PERIOD_BW = 12,
  parameter int DUR_BW    = 8,
  parameter int TICK_DIV  = 1000,
  parameter int GAP_TICKS = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  soundgen_tone_player_if.slave  note,
  output logic                   audio_o,
  output logic                   busy_o,
  output logic                   note_done_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [TW-1:0] PRE_LAST = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_TICKS);
  localparam bit            HAS_GAP  = (GAP_TICKS != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 accept_s;
  logic                 done_s;
  logic                 pre_wrap_s;

  logic                 ready_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 audio_r;
  logic [PERIOD_BW-1:0] period_r;
  logic [PERIOD_BW-1:0] hcnt_r;
  logic [DUR_BW-1:0]    rem_r;
  logic [TW-1:0]        pre_r;
  logic [GW-1:0]        gap_rem_r;

  assign note.note_ready_o = ready_r;
  assign busy_o            = busy_r;
  assign note_done_o       = done_r;
  assign audio_o           = audio_r;

  // Next-state and completion decode.
  always_comb begin
    state_next = state;
    done_s     = 1'b0;
    accept_s   = note.note_valid_i && ready_r;
    pre_wrap_s = (pre_r == PRE_LAST);
    case (state)
      IDLE: begin
        if (accept_s) begin
          if (note.note_dur_i != '0) begin
            state_next = PLAY;
          end else if (HAS_GAP) begin
            state_next = GAP;
          end else begin
            state_next = IDLE;
            done_s     = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      PLAY: begin
        // Last tick of the note ends on this prescaler wrap.
        if (pre_wrap_s && (rem_r == DUR_BW'(1))) begin
          if (HAS_GAP) begin
            state_next = GAP;
          end else begin
            state_next = IDLE;
            done_s     = 1'b1;
          end
        end else begin
          state_next = PLAY;
        end
      end
      GAP: begin
        if (pre_wrap_s && (gap_rem_r == GW'(1))) begin
          state_next = IDLE;
          done_s     = 1'b1;
        end else begin
          state_next = GAP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register, registered status outputs and note datapath.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      audio_r   <= 1'b0;
      period_r  <= '0;
      hcnt_r    <= '0;
      rem_r     <= '0;
      pre_r     <= '0;
      gap_rem_r <= '0;
    end else begin
      state   <= state_next;
      // Ready/busy are registered copies of the state being entered.
      ready_r <= (state_next == IDLE);
      busy_r  <= (state_next != IDLE);
      done_r  <= done_s;
      case (state)
        IDLE: begin
          hcnt_r    <= '0;
          pre_r     <= '0;
          audio_r   <= 1'b0;
          gap_rem_r <= GAP_LOAD;
          if (accept_s) begin
            period_r <= note.note_period_i;
            rem_r    <= note.note_dur_i;
          end else begin
            period_r <= period_r;
            rem_r    <= rem_r;
          end
        end
        PLAY: begin
          if (state_next != PLAY) begin
            // Leaving the tone phase: silence and restart the prescaler for the gap.
            hcnt_r  <= '0;
            pre_r   <= '0;
            audio_r <= 1'b0;
          end else begin
            if (pre_wrap_s) begin
              pre_r <= '0;
              rem_r <= rem_r - DUR_BW'(1);
            end else begin
              pre_r <= pre_r + TW'(1);
            end
            if (period_r == '0) begin
              hcnt_r  <= '0;
              audio_r <= 1'b0;
            end else if (hcnt_r == (period_r - PERIOD_BW'(1))) begin
              hcnt_r  <= '0;
              audio_r <= ~audio_r;
            end else begin
              hcnt_r <= hcnt_r + PERIOD_BW'(1);
            end
          end
        end
        GAP: begin
          audio_r <= 1'b0;
          hcnt_r  <= '0;
          if (pre_wrap_s) begin
            pre_r     <= '0;
            gap_rem_r <= gap_rem_r - GW'(1);
          end else begin
            pre_r <= pre_r + TW'(1);
          end
        end
        default: begin
          audio_r <= 1'b0;
          hcnt_r  <= '0;
          pre_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soundgen_tone_player.sv
module tb_soundgen_tone_player;
  localparam int PBW = 12;
  localparam int DBW = 8;
  localparam int TD  = 4;
  localparam int GT  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic audio;
  logic busy;
  logic done;

  soundgen_tone_player_if #(.PERIOD_BW(PBW), .DUR_BW(DBW)) ifc ();

  soundgen_tone_player #(
    .PERIOD_BW(PBW), .DUR_BW(DBW), .TICK_DIV(TD), .GAP_TICKS(GT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .note(ifc.slave),
    .audio_o(audio),
    .busy_o(busy),
    .note_done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int d;
  } note_t;

  int    tests = 0;
  int    fails = 0;
  note_t exp_q[$];
  int    obs[$];

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: a note of period p, duration d occupies (d+GAP)*TD busy
  // cycles; in tone cycle i the level is floor(i/p) mod 2 (0 for a rest).
  note_t cur;
  int    exp_len;
  int    bad_idx;
  int    e;

  // Monitor: collect the waveform while busy, score it on each done pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (done) check("done_during_reset", 1, 0);
      exp_q.delete();
      obs.delete();
    end else begin
      if (busy) obs.push_back(int'(audio));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          cur     = exp_q.pop_front();
          exp_len = (cur.d + GT) * TD;
          check("busy_cycles", obs.size(), exp_len);
          bad_idx = -1;
          for (int i = 0; i < obs.size(); i++) begin
            e = ((i < cur.d * TD) && (cur.p != 0)) ? ((i / cur.p) % 2) : 0;
            if ((obs[i] != e) && (bad_idx < 0)) bad_idx = i;
          end
          check("audio_trace_first_bad_cycle", bad_idx, -1);
          check("ready_with_done", int'(ifc.note_ready_o), 1);
          check("audio_at_done", int'(audio), 0);
        end
        obs.delete();
      end
    end
  end

  // Present a command at a falling edge; while the player is busy, drive
  // random junk (sometimes with valid) that must not be taken.
  task automatic send(input int p, input int d);
    int w = 0;
    while (!ifc.note_ready_o && (w < 3000)) begin
      ifc.note_valid_i  = 1'($urandom_range(0, 1));
      ifc.note_period_i = PBW'($urandom_range(0, 4095));
      ifc.note_dur_i    = DBW'($urandom_range(0, 255));
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      check("send_ready_timeout", w, 0);
    end else begin
      ifc.note_valid_i  = 1'b1;
      ifc.note_period_i = PBW'(p);
      ifc.note_dur_i    = DBW'(d);
      exp_q.push_back('{p: p, d: d});
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    ifc.note_valid_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int w = 0;
    ifc.note_valid_i = 1'b0;
    while (((exp_q.size() != 0) || busy) && (w < 2000)) begin
      @(negedge clk);
      w++;
    end
    check("pending_notes", exp_q.size(), 0);
  endtask

  initial begin
    ifc.note_valid_i  = 1'b0;
    ifc.note_period_i = '0;
    ifc.note_dur_i    = '0;

    // Reset state, with valid asserted to show it is ignored.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    ifc.note_valid_i = 1'b1;
    ifc.note_dur_i   = DBW'(1);
    @(negedge clk);
    check("reset_audio", int'(audio), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    ifc.note_valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", int'(ifc.note_ready_o), 1);
    check("busy_after_reset", int'(busy), 0);

    // Directed notes: normal, rest, zero duration, then back-to-back pair.
    send(3, 2);
    idle(20);
    send(0, 1);
    idle(12);
    send(5, 0);
    idle(8);
    send(2, 1);
    send(1, 1);
    drain();

    // Reset during the tone phase of a note.
    send(3, 2);
    repeat (4) @(negedge clk);
    ifc.note_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_audio", int'(audio), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", int'(ifc.note_ready_o), 1);
    check("abort_busy_after", int'(busy), 0);
    idle(20);

    // Randomized notes with random idle spacing (0 means back-to-back).
    for (int k = 0; k < 40; k++) begin
      send($urandom_range(0, 6), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
    end
    drain();
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
